// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RISC-V datapath: sequences fetch/decode/execute/
// memory/writeback, drives all mux selects and write enables, counts retired instructions.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             mem_to_reg,
  output logic             pc_src,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WR   = 4'd7,
    WB_ALU   = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t cur, nxt;
  logic   retire;

  // funct3 is decoded by the ALU control, not here; only beq semantics are sequenced.
  logic unused_funct3;
  assign unused_funct3 = ^funct3;

  assign state = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:   nxt = FETCH;
      FETCH:  if (mem_ready) nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:                nxt = EXEC_R;
          OP_I:                nxt = EXEC_I;
          OP_LOAD, OP_STORE:   nxt = MEM_ADDR;
          OP_BRANCH:           nxt = BRANCH;
          default:             nxt = FETCH;
        endcase
      end
      EXEC_R:   nxt = WB_ALU;
      EXEC_I:   nxt = WB_ALU;
      MEM_ADDR: nxt = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_ready) nxt = WB_MEM;
      MEM_WR:   if (mem_ready) nxt = FETCH;
      WB_ALU:   nxt = FETCH;
      WB_MEM:   nxt = FETCH;
      BRANCH:   nxt = FETCH;
      default:  nxt = IDLE;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    mem_to_reg = 1'b0;
    pc_src     = 1'b0;
    illegal    = 1'b0;
    case (cur)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        // ALU computes the branch target now so BRANCH can load it from ALUOut.
        alu_src_b = 2'b10;
        illegal   = !(opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH});
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b10;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      WB_ALU: reg_write = 1'b1;
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 1'b1;
        pc_write  = zero;
      end
      default: ;
    endcase
  end

  assign retire = (cur == WB_ALU) || (cur == WB_MEM) || (cur == BRANCH) ||
                  ((cur == MEM_WR) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle expected state/outputs/retired count queued by
// the instruction driver, popped and compared on the falling edge.
module tb_multicycle_ctrl;

  localparam int CW = 4;
  localparam int W  = 4 + 14 + CW;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
                         S_EXEC_I = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WR = 4'd7,
                         S_WB_ALU = 4'd8, S_WB_MEM = 4'd9, S_BRANCH = 4'd10;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [6:0]    opcode = '0;
  logic [2:0]    funct3 = '0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, alu_src_a;
  logic [1:0]    alu_src_b, alu_op;
  logic          mem_to_reg, pc_src, illegal;
  logic [CW-1:0] retired;
  logic [3:0]    state;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_to_reg(mem_to_reg), .pc_src(pc_src),
    .illegal(illegal), .retired(retired), .state(state)
  );

  logic [13:0] got_outs;
  assign got_outs = {pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, alu_src_a,
                     alu_src_b, alu_op, mem_to_reg, pc_src, illegal};

  // scoreboard
  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] ret_exp = '0;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
  endtask

  // Expected control word for one cycle, straight from the state table.
  function automatic logic [13:0] exp_outs(input logic [3:0] st, input logic mr, input logic z,
                                           input logic ill);
    logic pcw, irw, mrd, mwr, iod, rgw, asa, m2r, pcs, il;
    logic [1:0] asb, aop;
    {pcw, irw, mrd, mwr, iod, rgw, asa, m2r, pcs, il} = '0;
    asb = 2'b00;
    aop = 2'b00;
    case (st)
      S_FETCH:    begin mrd = 1; asb = 2'b01; pcw = mr; irw = mr; end
      S_DECODE:   begin asb = 2'b10; il = ill; end
      S_EXEC_R:   begin asa = 1; aop = 2'b10; end
      S_EXEC_I:   begin asa = 1; asb = 2'b10; aop = 2'b10; end
      S_MEM_ADDR: begin asa = 1; asb = 2'b10; end
      S_MEM_RD:   begin mrd = 1; iod = 1; end
      S_MEM_WR:   begin mwr = 1; iod = 1; end
      S_WB_ALU:   rgw = 1;
      S_WB_MEM:   begin rgw = 1; m2r = 1; end
      S_BRANCH:   begin asa = 1; aop = 2'b01; pcs = 1; pcw = z; end
      default:    ;
    endcase
    return {pcw, irw, mrd, mwr, iod, rgw, asa, asb, aop, m2r, pcs, il};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("state", 64'(state), 64'(e[W-1 -: 4]));
      check("outs", 64'(got_outs), 64'(e[CW +: 14]));
      check("retired", 64'(retired), 64'(e[CW-1:0]));
    end
  end

  // driver: called just after a rising edge; drives one cycle and queues its expectation
  task automatic step(input logic [3:0] st, input logic mr, input logic z, input logic ill,
                      input logic inc);
    mem_ready = mr;
    zero      = z;
    funct3    = 3'($urandom_range(0, 7));
    exp_q.push_back({st, exp_outs(st, mr, z, ill), ret_exp});
    if (inc) ret_exp = ret_exp + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic bz, input int fst, input int mst);
    logic legal;
    legal = (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_ST) || (op == OP_BR);
    opcode = op;
    for (int i = 0; i < fst; i++) step(S_FETCH, 1'b0, rnd(), 1'b0, 1'b0);
    step(S_FETCH, 1'b1, rnd(), 1'b0, 1'b0);
    step(S_DECODE, rnd(), rnd(), !legal, 1'b0);
    case (op)
      OP_R: begin
        step(S_EXEC_R, rnd(), rnd(), 1'b0, 1'b0);
        step(S_WB_ALU, rnd(), rnd(), 1'b0, 1'b1);
      end
      OP_I: begin
        step(S_EXEC_I, rnd(), rnd(), 1'b0, 1'b0);
        step(S_WB_ALU, rnd(), rnd(), 1'b0, 1'b1);
      end
      OP_LD: begin
        step(S_MEM_ADDR, rnd(), rnd(), 1'b0, 1'b0);
        for (int i = 0; i < mst; i++) step(S_MEM_RD, 1'b0, rnd(), 1'b0, 1'b0);
        step(S_MEM_RD, 1'b1, rnd(), 1'b0, 1'b0);
        step(S_WB_MEM, rnd(), rnd(), 1'b0, 1'b1);
      end
      OP_ST: begin
        step(S_MEM_ADDR, rnd(), rnd(), 1'b0, 1'b0);
        for (int i = 0; i < mst; i++) step(S_MEM_WR, 1'b0, rnd(), 1'b0, 1'b0);
        step(S_MEM_WR, 1'b1, rnd(), 1'b0, 1'b1);
      end
      OP_BR: step(S_BRANCH, rnd(), bz, 1'b0, 1'b1);
      default: ;
    endcase
  endtask

  // Reset asserted in the middle of a stalled store access.
  task automatic reset_in_mem_wr();
    opcode = OP_ST;
    step(S_FETCH, 1'b1, rnd(), 1'b0, 1'b0);
    step(S_DECODE, rnd(), rnd(), 1'b0, 1'b0);
    step(S_MEM_ADDR, rnd(), rnd(), 1'b0, 1'b0);
    mem_ready = 1'b0;
    check("mw_before_rst", 64'(mem_write), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mw_in_rst", 64'(mem_write), 64'd0);
    check("we_in_rst", 64'({pc_write, ir_write, mem_read, reg_write}), 64'd0);
    check("state_in_rst", 64'(state), 64'(S_IDLE));
    check("retired_in_rst", 64'(retired), 64'd0);
    ret_exp = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(S_IDLE, rnd(), rnd(), 1'b0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] op;
    int sel;
    @(posedge clk);
    #1;
    check("state_rst", 64'(state), 64'(S_IDLE));
    check("outs_rst", 64'(got_outs), 64'd0);
    check("retired_rst", 64'(retired), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(S_IDLE, rnd(), rnd(), 1'b0, 1'b0);

    run_instr(OP_R, 1'b0, 0, 0);
    run_instr(OP_LD, 1'b0, 0, 3);
    run_instr(OP_BR, 1'b1, 0, 0);
    run_instr(OP_BR, 1'b0, 0, 0);
    run_instr(OP_R, 1'b0, 5, 0);
    run_instr(7'b1111111, 1'b0, 0, 0);
    run_instr(OP_I, 1'b0, 1, 0);
    run_instr(OP_ST, 1'b0, 0, 2);
    run_instr(OP_ST, 1'b0, 0, 0);
    reset_in_mem_wr();

    // random mix; the 4-bit counter wraps several times
    for (int n = 0; n < 50; n++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: op = OP_R;
        1: op = OP_I;
        2: op = OP_LD;
        3: op = OP_ST;
        4: op = OP_BR;
        default: op = ($urandom_range(0, 1) == 0) ? 7'b0110111 : 7'b1111111;
      endcase
      run_instr(op, rnd(), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
